serial_transmitter: RTL and testbench

Byte-oriented asynchronous serial transmitter fed by the bit-rate tick from the clock-generator stage (the `transmitter_clock` output, 100 kHz from the 100 MHz `clk`). It accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and shifts each one out on `tx` as a framed character: start bit, data LSB first, optional parity, stop bit(s). All bit boundaries are aligned to rising edges of the tick.

---
 rtl/serial_pkg.sv | 7 +
 rtl/tx_fifo.sv | 44 ++++
 rtl/serial_transmitter.sv | 117 +++++++++++
 tb/tb_serial_transmitter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: transmitter FSM states and parity mode encodings shared by the serial transmitter files.
package serial_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous word FIFO with a registered occupancy count driving full/empty.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end
    assign dout  = mem_q[rd_q];
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: FIFO-buffered framed serial transmitter that advances only on rising edges of bit_tick.
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_tick,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(DATA_BITS + 1);
    tx_state_t state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, head;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic stop_cnt_q, stop_cnt_d, par_q, par_d, tx_q, tx_d, tick_q;
    logic tick_edge, full, empty, pop;

    tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(data_valid & data_ready),
        .pop(pop),
        .din(data_in),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );

    assign tick_edge  = bit_tick & ~tick_q;
    assign data_ready = ~full;
    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE) | (fifo_count != '0);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        if (tick_edge) begin
            case (state_q)
                ST_IDLE: pop = ~empty;
                ST_START: begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CW'(1);
                    state_d   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt_q == CW'(DATA_BITS)) begin
                        tx_d    = (PARITY != PARITY_NONE) ? par_q : 1'b1;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
                ST_PARITY: begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        pop     = ~empty;
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // A pop from IDLE or the last stop bit starts the next frame with no idle gap.
            if (pop) begin
                shift_d    = head;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                par_d      = (^head) ^ (PARITY == PARITY_ODD);
                tx_d       = 1'b0;
                state_d    = ST_START;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            tick_q     <= bit_tick;
        end
    end
endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter: drives four parity/stop-bit configurations in lockstep and checks
// every tick period of tx and busy against a frame-level model built from the pushed words.
module tb_serial_transmitter;
    logic clk = 1'b0, rst = 1'b1, bit_tick = 1'b0, data_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] tx_v, busy_v, ready_v;
    logic [2:0] cnt_v [4];
    logic exp_q [4][$];
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_transmitter #(
            .DATA_BITS(8),
            .PARITY(g == 1 ? 1 : g == 2 ? 2 : 0),
            .STOP_BITS(g == 3 ? 2 : 1),
            .FIFO_DEPTH(4)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bit_tick(bit_tick),
            .data_in(data_in),
            .data_valid(data_valid),
            .data_ready(ready_v[g]),
            .tx(tx_v[g]),
            .busy(busy_v[g]),
            .fifo_count(cnt_v[g])
        );
    end

    function automatic int par_of(input int i);
        return i == 1 ? 1 : i == 2 ? 2 : 0;
    endfunction

    function automatic int stop_of(input int i);
        return i == 3 ? 2 : 1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) exp_q[i].delete();
    endtask

    // One tx level per tick period: start, data LSB first, optional parity, stop bits.
    task automatic add_frame(input logic [7:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_q[i].push_back(1'b0);
            for (int b = 0; b < 8; b++) exp_q[i].push_back(w[b]);
            if (par_of(i) != 0) exp_q[i].push_back((^w) ^ (par_of(i) == 2));
            for (int s = 0; s < stop_of(i); s++) exp_q[i].push_back(1'b1);
        end
    endtask

    task automatic feed(input logic [7:0] ws[$]);
        foreach (ws[j]) begin
            int guard;
            guard = 0;
            data_in = ws[j];
            data_valid = 1'b1;
            while (1) begin
                @(negedge clk);
                if (&ready_v) break;
                guard++;
                if (guard > 20000) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL feed timeout word %0d: data_ready=%b required 1111", j, ready_v);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
    endtask

    task automatic run_ticks(input string name, input int nt, input int p, input bit square, input int freeze_k);
        for (int k = 0; k < nt; k++) begin
            int pe, h;
            pe = (k == freeze_k) ? 6 * p : p;
            h  = (k == freeze_k) ? 5 * p : square ? p / 2 : 1;
            for (int c = 0; c < pe; c++) begin
                @(posedge clk);
                #1;
                bit_tick = (c < h);
                if (c == pe - 1 || (k == freeze_k && (c == 2 || c == h - 1))) begin
                    for (int i = 0; i < 4; i++) begin
                        logic et, eb;
                        et = (k < exp_q[i].size()) ? exp_q[i][k] : 1'b1;
                        eb = k < exp_q[i].size();
                        n_cmp += 2;
                        if (tx_v[i] !== et) begin
                            n_err++;
                            $display("FAIL %s tx dut%0d tick %0d cyc %0d: got %b required %b", name, i, k, c, tx_v[i], et);
                        end
                        if (busy_v[i] !== eb) begin
                            n_err++;
                            $display("FAIL %s busy dut%0d tick %0d cyc %0d: got %b required %b", name, i, k, c, busy_v[i], eb);
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_stream(input string name, input logic [7:0] ws[$], input int p, input bit square, input int freeze_k);
        int n_exp, nt;
        clear_model();
        foreach (ws[j]) add_frame(ws[j]);
        nt = 11 * ws.size() + 3;
        n_exp = ws.size() < 4 ? ws.size() : 4;
        fork
            feed(ws);
            begin
                repeat (8) @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) begin
                    n_cmp += 3;
                    if (cnt_v[i] !== 3'(n_exp)) begin
                        n_err++;
                        $display("FAIL %s fifo_count dut%0d: got %0d required %0d", name, i, cnt_v[i], n_exp);
                    end
                    if (ready_v[i] !== (n_exp < 4)) begin
                        n_err++;
                        $display("FAIL %s data_ready dut%0d: got %b required %b", name, i, ready_v[i], n_exp < 4);
                    end
                    if (busy_v[i] !== 1'b1) begin
                        n_err++;
                        $display("FAIL %s busy before tick dut%0d: got %b required 1", name, i, busy_v[i]);
                    end
                end
                run_ticks(name, nt, p, square, freeze_k);
            end
        join
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_valid = 1'b1;
        data_in = 8'h3C;
        bit_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp += 4;
            if (tx_v[i] !== 1'b1) begin n_err++; $display("FAIL reset tx dut%0d: got %b required 1", i, tx_v[i]); end
            if (busy_v[i] !== 1'b0) begin n_err++; $display("FAIL reset busy dut%0d: got %b required 0", i, busy_v[i]); end
            if (ready_v[i] !== 1'b1) begin n_err++; $display("FAIL reset data_ready dut%0d: got %b required 1", i, ready_v[i]); end
            if (cnt_v[i] !== 3'd0) begin n_err++; $display("FAIL reset fifo_count dut%0d: got %0d required 0", i, cnt_v[i]); end
        end
        data_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cnt_v[i] !== 3'd0) begin n_err++; $display("FAIL post-reset fifo_count dut%0d: got %0d required 0", i, cnt_v[i]); end
        end
    endtask

    task automatic test_single();
        logic [7:0] ws[$];
        ws.push_back(8'hA5);
        run_stream("single_a5", ws, 1000, 1'b0, -1);
    endtask

    task automatic test_parity();
        for (int r = 0; r < 3; r++) begin
            logic [7:0] ws[$];
            ws.push_back(r == 0 ? 8'hA5 : 8'($urandom));
            run_stream("parity", ws, $urandom_range(4, 24), 1'($urandom), -1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ws[$];
        for (int j = 1; j <= 5; j++) ws.push_back(8'(j));
        run_stream("back_to_back", ws, 12, 1'b0, -1);
    endtask

    task automatic test_stop_bits();
        logic [7:0] ws[$];
        ws.push_back(8'h00);
        ws.push_back(8'($urandom));
        run_stream("stop_bits", ws, 10, 1'b0, -1);
    endtask

    task automatic test_tick_form();
        logic [7:0] ws[$];
        ws.push_back(8'($urandom));
        run_stream("tick_pulse", ws, 16, 1'b0, -1);
        run_stream("tick_square", ws, 16, 1'b1, -1);
        run_stream("tick_hold", ws, 10, 1'($urandom), $urandom_range(1, 9));
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [7:0] ws[$];
            int n;
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) ws.push_back(8'($urandom));
            run_stream("random", ws, $urandom_range(4, 24), 1'($urandom), -1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ws[$];
        ws.push_back(8'h00);
        ws.push_back(8'hFF);
        ws.push_back(8'h55);
        clear_model();
        foreach (ws[j]) add_frame(ws[j]);
        feed(ws);
        run_ticks("mid_frame", 4, 10, 1'b0, -1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp += 3;
            if (tx_v[i] !== 1'b1) begin n_err++; $display("FAIL async reset tx dut%0d: got %b required 1", i, tx_v[i]); end
            if (cnt_v[i] !== 3'd0) begin n_err++; $display("FAIL async reset fifo_count dut%0d: got %0d required 0", i, cnt_v[i]); end
            if (busy_v[i] !== 1'b0) begin n_err++; $display("FAIL async reset busy dut%0d: got %b required 0", i, busy_v[i]); end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        run_ticks("after_reset", 25, 10, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_stop_bits();
        test_tick_form();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
